// File: rtl/sha3_scan_sequencer.sv
// Feeds a contiguous nonce range to the SHA3 core with a bounded in-flight window and queues found nonces for software.
// Optional interrupt pair (irq/irq_ack) is built only when SHA3_SCAN_IRQ_EN is defined.
module sha3_scan_sequencer #(
  parameter int NONCE_W      = 32,
  parameter int MAX_INFLIGHT = 8,
  parameter int RESULT_DEPTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          cfg_start,
  input  logic                          cfg_stop,
  input  logic [NONCE_W-1:0]            cfg_first_nonce,
  input  logic [NONCE_W-1:0]            cfg_count,
  output logic                          core_nonce_valid,
  input  logic                          core_nonce_ready,
  output logic [NONCE_W-1:0]            core_nonce,
  input  logic                          core_res_valid,
  input  logic                          core_res_found,
  input  logic [NONCE_W-1:0]            core_res_nonce,
  input  logic                          res_pop,
  output logic [NONCE_W-1:0]            res_nonce,
  output logic                          res_empty,
  output logic [$clog2(RESULT_DEPTH):0] res_level,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
`ifdef SHA3_SCAN_IRQ_EN
  ,
  output logic                          irq,
  input  logic                          irq_ack
`endif
);

  localparam int IFW  = $clog2(MAX_INFLIGHT) + 1;
  localparam int PTRW = $clog2(RESULT_DEPTH);
  localparam int LVLW = PTRW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] remain_q, remain_d;
  logic [IFW-1:0]     inflight_q, inflight_d;
  logic               nonce_vld_q, nonce_vld_d;
  logic               ovf_q, ovf_d;

  logic [NONCE_W-1:0] fifo_q [RESULT_DEPTH];
  logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LVLW-1:0]    level_q, level_d;

  logic start_ok;
  logic issue_fire;
  logic res_ok;
  logic push_req;
  logic pop_ok;
  logic fifo_full;
  logic push_ok;

  // Handshake and result qualification
  always_comb begin
    start_ok   = cfg_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    issue_fire = nonce_vld_q && core_nonce_ready;
    // A result with nothing outstanding is a core protocol error and is dropped.
    res_ok     = core_res_valid && (state_q != S_IDLE) && (inflight_q != '0);
    push_req   = res_ok && core_res_found;
    pop_ok     = res_pop && (level_q != '0);
    fifo_full  = (level_q == LVLW'(RESULT_DEPTH));
    push_ok    = push_req && (!fifo_full || pop_ok);
  end

  always_comb begin
    state_d     = state_q;
    nonce_d     = nonce_q;
    remain_d    = remain_q;
    ovf_d       = ovf_q;
    inflight_d  = inflight_q + IFW'(issue_fire) - IFW'(res_ok);
    nonce_vld_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          nonce_d  = cfg_first_nonce;
          remain_d = cfg_count;
          ovf_d    = 1'b0;
          state_d  = (cfg_count == '0) ? S_DRAIN : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (issue_fire) begin
          nonce_d  = nonce_q + NONCE_W'(1);
          remain_d = remain_q - NONCE_W'(1);
        end
        if (cfg_stop) begin
          remain_d = '0;
        end
        if (remain_d == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push_req && fifo_full && !pop_ok) begin
      ovf_d = 1'b1;
    end

    // Offer is computed from next-cycle state so valid is registered yet never lags a slot opening.
    nonce_vld_d = (state_d == S_DISPATCH) && (remain_d != '0) &&
                  (inflight_d < IFW'(MAX_INFLIGHT));
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      nonce_q     <= '0;
      remain_q    <= '0;
      inflight_q  <= '0;
      nonce_vld_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nonce_q     <= nonce_d;
      remain_q    <= remain_d;
      inflight_q  <= inflight_d;
      nonce_vld_q <= nonce_vld_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    level_d  = level_q + LVLW'(push_ok) - LVLW'(pop_ok);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < RESULT_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= core_res_nonce;
      end
    end
  end

`ifdef SHA3_SCAN_IRQ_EN
  logic irq_q, irq_d;
  logic irq_evt;

  // A new event in the same cycle as an acknowledge keeps the interrupt pending.
  always_comb begin
    irq_evt = push_ok || ((state_d == S_DONE) && (state_q != S_DONE));
    irq_d   = irq_evt || (irq_q && !irq_ack);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  assign core_nonce_valid = nonce_vld_q;
  assign core_nonce       = nonce_q;
  assign res_nonce        = (level_q != '0) ? fifo_q[rd_ptr_q] : '0;
  assign res_empty        = (level_q == '0);
  assign res_level        = level_q;
  assign busy             = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
  assign done             = (state_q == S_DONE);
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_sha3_scan_sequencer.sv
// Randomised bench for sha3_scan_sequencer: core/software stimulus plus a queue-based reference model.
// Interrupt checks are compiled when SHA3_SCAN_IRQ_EN is defined.
module tb_sha3_scan_sequencer;
  localparam int NW = 32;
  localparam int MI = 8;
  localparam int RD = 4;
  localparam int P_IDLE = 0, P_DISP = 1, P_DRAIN = 2, P_DONE = 3;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          cfg_start = 0, cfg_stop = 0;
  logic [NW-1:0] cfg_first_nonce = '0, cfg_count = '0;
  logic          core_nonce_valid, core_nonce_ready = 0;
  logic [NW-1:0] core_nonce;
  logic          core_res_valid = 0, core_res_found = 0;
  logic [NW-1:0] core_res_nonce = '0;
  logic          res_pop = 0;
  logic [NW-1:0] res_nonce;
  logic          res_empty;
  logic [2:0]    res_level;
  logic          busy, done, overflow;
`ifdef SHA3_SCAN_IRQ_EN
  logic irq, irq_ack = 0;
  logic req_ack = 0;
  logic m_irq;
`endif

  sha3_scan_sequencer #(.NONCE_W(NW), .MAX_INFLIGHT(MI), .RESULT_DEPTH(RD)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_first_nonce(cfg_first_nonce), .cfg_count(cfg_count),
    .core_nonce_valid(core_nonce_valid), .core_nonce_ready(core_nonce_ready), .core_nonce(core_nonce),
    .core_res_valid(core_res_valid), .core_res_found(core_res_found), .core_res_nonce(core_res_nonce),
    .res_pop(res_pop), .res_nonce(res_nonce), .res_empty(res_empty), .res_level(res_level),
    .busy(busy), .done(done), .overflow(overflow)
`ifdef SHA3_SCAN_IRQ_EN
    , .irq(irq), .irq_ack(irq_ack)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0, n_fail = 0, cyc_n = 0;

  // Reference model
  int            m_phase, m_infl;
  logic [NW-1:0] m_next, m_rem;
  logic          m_vld, m_ovf;
  logic [NW-1:0] m_fifo[$];

  // Core model
  typedef struct { logic [NW-1:0] nonce; logic found; int due; } pend_t;
  pend_t pend[$];
  int lat = 4, rdy_mode = 0, rdy_after = 0, find_mode = 0, max_pend = 0;
  logic pop_rand = 0;

  // Requests from the scenario, applied at the next drive point
  logic          req_rst_n = 0, req_start = 0, req_stop = 0, req_pop = 0, req_spurious = 0;
  logic [NW-1:0] req_first = '0, req_count = '0;

  // Per-scan bookkeeping
  logic [NW-1:0] exp_issue;
  logic [NW-1:0] issued_log[$];
  int   issued = 0, answered = 0, last_res_cyc = -1, start_cyc = 0, first_fire_cyc = -1;
  logic prev_vld = 0, prev_rdy = 0, prev_stop = 0;
  logic [NW-1:0] prev_nonce = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic found_of(input logic [NW-1:0] n);
    case (find_mode)
      1: return (n == 3) || (n == 7) || (n == 9) || (n == 11) || (n == 13);
      2: return ($urandom_range(0, 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_infl = 0; m_next = '0; m_rem = '0; m_vld = 0; m_ovf = 0;
    m_fifo.delete();
`ifdef SHA3_SCAN_IRQ_EN
    m_irq = 0;
`endif
  endtask

  task automatic model_step();
    logic fire, res_ok, pop_ok, pushed;
    int old_phase, old_infl;
    fire      = m_vld && core_nonce_ready;
    res_ok    = core_res_valid && (m_phase != P_IDLE) && (m_infl > 0);
    pop_ok    = res_pop && (m_fifo.size() > 0);
    old_phase = m_phase;
    old_infl  = m_infl;
    pushed    = 0;
    if ((m_phase == P_IDLE || m_phase == P_DONE) && cfg_start) begin
      m_next = cfg_first_nonce; m_rem = cfg_count; m_ovf = 0;
      m_phase = (cfg_count == 0) ? P_DRAIN : P_DISP;
    end else if (m_phase == P_DISP) begin
      if (fire) begin m_next = m_next + 1; m_rem = m_rem - 1; end
      if (cfg_stop) m_rem = 0;
      if (m_rem == 0) m_phase = P_DRAIN;
    end else if (m_phase == P_DRAIN && old_infl == 0) begin
      m_phase = P_DONE;
    end
    if (pop_ok) void'(m_fifo.pop_front());
    if (res_ok && core_res_found) begin
      if (m_fifo.size() < RD) begin m_fifo.push_back(core_res_nonce); pushed = 1; end
      else m_ovf = 1;
    end
    if (res_ok) begin answered++; last_res_cyc = cyc_n; end
    m_infl = old_infl + int'(fire) - int'(res_ok);
    m_vld  = (m_phase == P_DISP) && (m_rem != 0) && (m_infl < MI);
`ifdef SHA3_SCAN_IRQ_EN
    if (pushed || (m_phase == P_DONE && old_phase != P_DONE)) m_irq = 1;
    else if (irq_ack) m_irq = 0;
`endif
  endtask

  task automatic compare();
    chk("core_nonce_valid", core_nonce_valid, m_vld);
    if (m_vld) chk("core_nonce", core_nonce, m_next);
    chk("busy", busy, (m_phase == P_DISP) || (m_phase == P_DRAIN));
    chk("done", done, m_phase == P_DONE);
    chk("overflow", overflow, m_ovf);
    chk("res_empty", res_empty, m_fifo.size() == 0);
    chk("res_level", res_level, m_fifo.size());
    chk("res_nonce", res_nonce, (m_fifo.size() > 0) ? m_fifo[0] : 0);
`ifdef SHA3_SCAN_IRQ_EN
    chk("irq", irq, m_irq);
`endif
    if (prev_vld && !prev_rdy && !prev_stop && ARESETN) begin
      chk("valid_hold", core_nonce_valid, 1);
      chk("nonce_hold", core_nonce, prev_nonce);
    end
  endtask

  // One clock: check outputs, drive inputs for the next edge, advance the model.
  task automatic cyc();
    pend_t p;
    logic fire;
    @(negedge ACLK);
    cyc_n++;
    compare();
    ARESETN = req_rst_n;
    cfg_start = req_start; cfg_stop = req_stop; req_start = 0; req_stop = 0;
    cfg_first_nonce = req_first; cfg_count = req_count;
    res_pop = pop_rand ? ($urandom_range(0, 2) == 0) : req_pop; req_pop = 0;
`ifdef SHA3_SCAN_IRQ_EN
    irq_ack = req_ack | (pop_rand && ($urandom_range(0, 3) == 0)); req_ack = 0;
`endif
    case (rdy_mode)
      0: core_nonce_ready = 1;
      1: core_nonce_ready = ($urandom_range(0, 1) == 1);
      default: core_nonce_ready = (cyc_n >= rdy_after);
    endcase
    core_res_valid = 0; core_res_found = 1'($urandom_range(0, 1)); core_res_nonce = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      p = pend.pop_front();
      core_res_valid = 1; core_res_found = p.found; core_res_nonce = p.nonce;
    end else if (req_spurious) begin
      core_res_valid = 1; core_res_found = 1; core_res_nonce = 32'hDEAD_BEEF;
    end
    req_spurious = 0;
    fire = ARESETN && core_nonce_valid && core_nonce_ready;
    if (fire) begin
      chk("issue_order", core_nonce, exp_issue);
      if (issued == 0) first_fire_cyc = cyc_n;
      exp_issue = exp_issue + 1;
      issued++;
      issued_log.push_back(core_nonce);
      pend.push_back('{nonce: core_nonce, found: found_of(core_nonce), due: cyc_n + lat});
    end
    if (ARESETN) chk("inflight_bound", pend.size() <= MI, 1);
    if (pend.size() > max_pend) max_pend = pend.size();
    prev_vld = ARESETN && core_nonce_valid; prev_rdy = core_nonce_ready;
    prev_stop = cfg_stop; prev_nonce = core_nonce;
    if (!ARESETN) model_reset(); else model_step();
  endtask

  task automatic start_scan(input logic [NW-1:0] first, input logic [NW-1:0] cnt);
    req_start = 1; req_first = first; req_count = cnt;
    exp_issue = first; issued = 0; answered = 0; issued_log.delete();
    first_fire_cyc = -1; max_pend = 0;
    cyc();
    start_cyc = cyc_n;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (done === 1'b1) begin dcyc = cyc_n; break; end
    end
    if (dcyc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: done never rose within %0d cycles", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc, at_stop;
    logic [NW-1:0] e;
    logic [NW-1:0] t3_exp[4];
    logic [NW-1:0] t4_exp[4];
    t3_exp = '{32'h3, 32'h7, 32'h9, 32'hB};
    t4_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    model_reset();

    // Reset values
    repeat (3) cyc();
    chk("rst_res_empty", res_empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", core_nonce_valid, 0);
    req_rst_n = 1;
    repeat (2) cyc();

    // Basic range, ready always, latency 4, no finds
    lat = 4; rdy_mode = 0; find_mode = 0;
    start_scan(32'h100, 16);
    wait_done(200, dc);
    chk("t1_issued", issued, 16);
    for (int k = 0; k < 16 && k < issued_log.size(); k++) begin
      e = 32'h100 + k;
      chk("t1_nonce", issued_log[k], e);
    end
    chk("t1_start_latency", first_fire_cyc, start_cyc + 1);
    chk("t1_done_latency", dc, last_res_cyc + 2);
    chk("t1_res_empty", res_empty, 1);

    // Stalled core, long latency
    lat = 30; rdy_mode = 2; rdy_after = cyc_n + 20;
    start_scan(32'h2000, 20);
    wait_done(400, dc);
    chk("t2_issued", issued, 20);
    chk("t2_peak_inflight", max_pend, 8);
    chk("t2_answered", answered, 20);

    // Finds overflowing the result FIFO
    lat = 4; rdy_mode = 0; find_mode = 1;
    start_scan(32'h0, 16);
    wait_done(200, dc);
    chk("t3_level", res_level, 4);
    chk("t3_overflow", overflow, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t3_head", res_nonce, t3_exp[k]);
      req_pop = 1; cyc(); cyc();
    end
    chk("t3_empty", res_empty, 1);
    chk("t3_overflow_sticky", overflow, 1);

    // Nonce wrap
    find_mode = 0;
    start_scan(32'hFFFF_FFFE, 4);
    wait_done(100, dc);
    chk("t4_issued", issued, 4);
    for (int k = 0; k < 4 && k < issued_log.size(); k++) chk("t4_nonce", issued_log[k], t4_exp[k]);
    chk("t4_overflow_cleared", overflow, 0);

    // Abort, start while busy, spurious result, zero count
    start_scan(32'h500, 100);
    for (int i = 0; i < 50 && issued < 5; i++) cyc();
    req_stop = 1; cyc();
    at_stop = issued;
    req_start = 1; req_first = 32'h9999; cyc();
    wait_done(100, dc);
    chk("t5_no_issue_after_stop", issued, at_stop);
    chk("t5_results_drained", answered, at_stop);
    req_spurious = 1; cyc(); cyc();
    chk("t5_spurious_dropped", res_level, 0);
    req_stop = 1;
    start_scan(32'h700, 0);
    wait_done(20, dc);
    chk("t5_zero_issued", issued, 0);
    chk("t5_zero_done_latency", dc, start_cyc + 2);

    // Reset in the middle of a scan; stale results must be ignored
    find_mode = 1;
    start_scan(32'h0, 50);
    repeat (10) cyc();
    req_rst_n = 0; cyc();
    #1;
    chk("t6_rst_valid", core_nonce_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_nonce", core_nonce, 0);
    chk("t6_rst_empty", res_empty, 1);
    repeat (2) cyc();
    req_rst_n = 1;
    for (int i = 0; i < 60 && pend.size() > 0; i++) cyc();
    repeat (3) cyc();
    chk("t6_stale_ignored", res_level, 0);
    chk("t6_idle", busy, 0);

`ifdef SHA3_SCAN_IRQ_EN
    lat = 12;
    start_scan(32'h3, 4);
    for (int i = 0; i < 60 && irq !== 1'b1; i++) cyc();
    chk("t7_irq_on_find", irq, 1);
    req_ack = 1; cyc(); cyc();
    chk("t7_irq_acked", irq, 0);
    wait_done(60, dc);
    chk("t7_irq_on_done", irq, 1);
    req_pop = 1; cyc(); cyc();
`endif

    // Randomised scans
    for (int it = 0; it < 8; it++) begin
      int stop_at;
      lat = $urandom_range(1, 12); rdy_mode = 1; find_mode = 2; pop_rand = 1;
      stop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 25) : -1;
      start_scan($urandom, NW'($urandom_range(0, 40)));
      dc = -1;
      for (int i = 0; i < 1500; i++) begin
        if (i == stop_at && m_phase == P_DISP) req_stop = 1;
        if (i == 7 && m_phase == P_DISP) begin req_start = 1; req_first = 32'h5555; end
        if (m_infl == 0 && pend.size() == 0 && $urandom_range(0, 20) == 0) req_spurious = 1;
        cyc();
        if (done === 1'b1) begin dc = cyc_n; break; end
      end
      if (dc < 0) begin
        n_tests++; n_fail++;
        $display("FAIL rnd_timeout: scan %0d never completed", it);
      end
      chk("rnd_answered", answered, issued);
      repeat (3) cyc();
    end
    pop_rand = 0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sha3_scan_sequencer.md
Name: sha3_scan_sequencer

Overview:
Control sequencer between the AXI4-Lite register file and the SHA3 scanner hash pipeline. On a start command it issues a contiguous nonce range to the core over a valid/ready handshake and bounds the number of nonces in flight. It collects "found" results into a small result FIFO that software pops, and reports busy/done/overflow status back to the register file.

Parameters:
NONCE_W, 32, nonce and count width
MAX_INFLIGHT, 8, max nonces issued but not yet answered by the core (power of two, ≥2)
RESULT_DEPTH, 4, result FIFO entries (power of two, ≥2)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle start pulse; ignored unless IDLE or DONE
cfg_stop  in  1  one-cycle abort pulse
cfg_first_nonce  in  NONCE_W  first nonce; sampled on accepted start
cfg_count  in  NONCE_W  number of nonces; sampled on accepted start
core_nonce_valid  out  1  nonce offer to core
core_nonce_ready  in  1  core accepts nonce
core_nonce  out  NONCE_W  nonce to hash
core_res_valid  in  1  one result per issued nonce, in issue order
core_res_found  in  1  result meets target
core_res_nonce  in  NONCE_W  nonce of that result
res_pop  in  1  pop FIFO head; ignored when empty
res_nonce  out  NONCE_W  FIFO head; 0 when empty
res_empty  out  1  FIFO empty
res_level  out  clog2(RESULT_DEPTH)+1  FIFO occupancy
busy  out  1  state is DISPATCH or DRAIN
done  out  1  state is DONE
overflow  out  1  sticky: found result lost because FIFO was full

Behaviour:
- Reset: state IDLE; all outputs 0 except res_empty=1; counters and FIFO cleared. Reset asserted mid-scan abandons the scan immediately; results arriving after reset release are ignored until the next start.
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE/DONE + cfg_start: latch next_nonce=cfg_first_nonce, remaining=cfg_count, clear overflow; FIFO is NOT cleared. Next state is DISPATCH, or DRAIN if cfg_count==0 (DRAIN then passes directly to DONE with nothing in flight).
- DISPATCH: core_nonce_valid = (remaining!=0) && (inflight<MAX_INFLIGHT); core_nonce=next_nonce. On handshake: next_nonce+=1 (wraps mod 2^NONCE_W), remaining-=1, inflight+=1. When remaining reaches 0 → DRAIN.
- core_nonce_valid is registered. Once asserted it holds with stable core_nonce until ready, except when cfg_stop arrives.
- Result path, active in every state except IDLE: each core_res_valid decrements inflight. A simultaneous issue and result leaves inflight unchanged. If core_res_found is set, core_res_nonce is pushed into the FIFO; if the FIFO is full (with no same-cycle pop), the push is dropped and overflow is set.
- FIFO: a simultaneous pop and push when full succeeds (level unchanged). A simultaneous pop and push when empty: the pop is ignored, the push lands, and res_nonce shows it next cycle. res_nonce, res_empty and res_level are registered and valid one cycle after the push.
- DRAIN: → DONE in the cycle after inflight==0.
- cfg_stop in DISPATCH: remaining←0, core_nonce_valid drops next cycle, → DRAIN. Nonces already issued still drain and may still push results. cfg_stop in other states is ignored.
- cfg_start while busy is ignored. Simultaneous cfg_start and cfg_stop in IDLE/DONE: start wins.
- core_res_valid with inflight==0 is a protocol error: no decrement, no push.
- Latency: start pulse at cycle N → core_nonce_valid at N+1. Last result at cycle M → done at M+2.

Optional Feature:
SHA3_SCAN_IRQ_EN: adds ports irq (out, 1) and irq_ack (in, 1).
- irq rises (registered) on entry to DONE or on any successful FIFO push.
- irq stays high until an irq_ack pulse. irq_ack in the same cycle as a new event leaves irq set.
- Without the macro these ports do not exist and no interrupt logic is synthesized.

Test Plan:
- MAX_INFLIGHT=8, core_nonce_ready=1, core returns a result 4 cycles after issue, no finds; start first_nonce=0x100, count=16 → nonces 0x100..0x10F issued in order; done high 2 cycles after the last result; res_empty=1.
- Core ready=0 until 20 cycles elapse, then results return with latency 30; count=20 → inflight never exceeds 8; valid held with stable nonce while stalled; all 20 issued exactly once.
- Found on nonces 0x3, 0x7, 0x9, 0xB, 0xD with RESULT_DEPTH=4 and no pops → FIFO holds 3,7,9,B; overflow=1; four pops return those in order, then res_empty=1.
- first_nonce=0xFFFFFFFE, count=4 → nonces FFFFFFFE, FFFFFFFF, 0, 1.
- cfg_stop after 5 issues of count=100 → no further issues, done after in-flight results drain, results counted; cfg_start while busy ignored; count=0 → DONE with no issue.
- ARESETN low during DISPATCH → all outputs reset immediately; then with SHA3_SCAN_IRQ_EN: one found → irq=1, irq_ack clears it, DONE sets it again.
